// File: rtl/bla_sub_pipe2.sv
// bla_sub_pipe2: two-stage pipelined borrow-lookahead subtractor.
// Computes diff = a - b - bin with unsigned borrow-out and signed overflow.
// Stage 1 resolves the low half and its borrow. Stage 2 resolves the high
// half from that registered borrow. Valid/ready handshakes on both sides,
// throughput one op per cycle, no combinational path from operands to outputs.
module bla_sub_pipe2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  // Borrow-lookahead over the low half. Returns {borrow_out, difference}.
  // Each borrow is formed from the running group generate/propagate of the
  // bits below it combined with the incoming borrow, rather than from the
  // previous bit's borrow.
  function automatic logic [LO:0] bla_lo(input logic [LO-1:0] x,
                                         input logic [LO-1:0] y,
                                         input logic          bi);
    logic [LO-1:0] g;
    logic [LO-1:0] p;
    logic [LO:0]   br;
    logic          gg;
    logic          pp;
    g     = ~x & y;
    p     = ~(x ^ y);
    gg    = 1'b0;
    pp    = 1'b1;
    br[0] = bi;
    for (int i = 0; i < LO; i++) begin
      gg      = g[i] | (p[i] & gg);
      pp      = p[i] & pp;
      br[i+1] = gg | (pp & bi);
    end
    return {br[LO], x ^ y ^ br[LO-1:0]};
  endfunction

  // Borrow-lookahead over the high half, same structure as bla_lo.
  function automatic logic [HI:0] bla_hi(input logic [HI-1:0] x,
                                         input logic [HI-1:0] y,
                                         input logic          bi);
    logic [HI-1:0] g;
    logic [HI-1:0] p;
    logic [HI:0]   br;
    logic          gg;
    logic          pp;
    g     = ~x & y;
    p     = ~(x ^ y);
    gg    = 1'b0;
    pp    = 1'b1;
    br[0] = bi;
    for (int i = 0; i < HI; i++) begin
      gg      = g[i] | (p[i] & gg);
      pp      = p[i] & pp;
      br[i+1] = gg | (pp & bi);
    end
    return {br[HI], x ^ y ^ br[HI-1:0]};
  endfunction

  // Handshake control
  logic accept;
  logic s2_free;
  logic s1_adv;

  logic s1_valid_q;
  logic s1_valid_d;
  logic out_valid_q;
  logic out_valid_d;

  // Stage 1 registers: low-half result, its borrow, and the high-half operands
  logic [LO-1:0] s1_dlo_q;
  logic          s1_br_q;
  logic [HI-1:0] s1_ahi_q;
  logic [HI-1:0] s1_bhi_q;

  // Stage 2 (output) registers
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  // Combinational lookahead results
  logic [LO:0]   lo_res;
  logic [HI:0]   hi_res;
  logic [HI-1:0] hi_d;
  logic          hi_br;
  logic          ovf_d;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  assign lo_res = bla_lo(a[LO-1:0], b[LO-1:0], bin);
  assign hi_res = bla_hi(s1_ahi_q, s1_bhi_q, s1_br_q);
  assign hi_d   = hi_res[HI-1:0];
  assign hi_br  = hi_res[HI];

  // Overflow: operands of opposite sign and result sign differs from minuend
  assign ovf_d = (s1_ahi_q[HI-1] ^ s1_bhi_q[HI-1]) & (hi_d[HI-1] ^ s1_ahi_q[HI-1]);

  // Next-state of the two valid flags; stage 1 may reload while it drains
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Valid flags; reset discards every op in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---- stage 1: capture low-half result, borrow into high half, high operands
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_dlo_q <= lo_res[LO-1:0];
      s1_br_q  <= lo_res[LO];
      s1_ahi_q <= a[WIDTH-1:LO];
      s1_bhi_q <= b[WIDTH-1:LO];
    end
  end

  // ---- stage 2: resolve high half and load results; hold under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (s1_adv) begin
      diff_q <= {hi_d, s1_dlo_q};
      bout_q <= hi_br;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bla_sub_pipe2.sv
// Scoreboard bench for bla_sub_pipe2 at WIDTH=8 and WIDTH=16.
module tb_bla_sub_pipe2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        bin;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        in_ready8, ov8, bout8, ovf8;
  logic [7:0]  diff8;
  logic        in_ready16, ov16, bout16, ovf16;
  logic [15:0] diff16;

  bla_sub_pipe2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin), .out_valid(ov8), .out_ready(out_ready),
    .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  bla_sub_pipe2 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a16), .b(b16), .bin(bin), .out_valid(ov16), .out_ready(out_ready),
    .diff(diff16), .bout(bout16), .ovf(ovf16)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        o;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  logic       hand_vld;
  logic [7:0] hand_d;
  logic       hand_b;
  logic       hand_o;

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] r;
    exp_t e;
    r   = {1'b0, x} - {1'b0, y} - {8'h00, bi};
    e.d = {8'h00, r[7:0]};
    e.b = r[8];
    e.o = (x[7] != y[7]) && (r[7] != x[7]);
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] r;
    exp_t e;
    r   = {1'b0, x} - {1'b0, y} - {16'h0000, bi};
    e.d = r[15:0];
    e.b = r[16];
    e.o = (x[15] != y[15]) && (r[15] != x[15]);
    return e;
  endfunction

  // Scoreboard: push on accept, peek/compare whenever a result is presented, pop on consume
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q8.delete();
      q16.delete();
    end else begin
      if (ov8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out8_unexpected actual=%0h required=none (t=%0t)", diff8, $time);
        end else begin
          e = q8[0];
          chk("diff8", {24'h0, diff8}, {24'h0, e.d[7:0]});
          chk("bout8", {31'h0, bout8}, {31'h0, e.b});
          chk("ovf8",  {31'h0, ovf8},  {31'h0, e.o});
          if (out_ready) void'(q8.pop_front());
        end
      end
      if (ov16) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out16_unexpected actual=%0h required=none (t=%0t)", diff16, $time);
        end else begin
          e = q16[0];
          chk("diff16", {16'h0, diff16}, {16'h0, e.d});
          chk("bout16", {31'h0, bout16}, {31'h0, e.b});
          chk("ovf16",  {31'h0, ovf16},  {31'h0, e.o});
          if (out_ready) void'(q16.pop_front());
        end
      end
      if (in_valid && in_ready8) begin
        if (hand_vld) begin
          e.d = {8'h00, hand_d};
          e.b = hand_b;
          e.o = hand_o;
        end else begin
          e = model8(a8, b8, bin);
        end
        q8.push_back(e);
        acc_cnt++;
      end
      if (in_valid && in_ready16) q16.push_back(model16(a16, b16, bin));
    end
  end

  // Present one op with its hand-computed 8-bit result; returns one tick after the accepting edge
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    in_valid = 1'b1;
    a8  = x;
    b8  = y;
    bin = bi;
    a16 = {x, ~y};
    b16 = {y, x};
    hand_vld = 1'b1;
    hand_d   = ed;
    hand_b   = eb;
    hand_o   = eo;
    n = 0;
    while (!in_ready8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=in_ready_low required=accept (t=%0t)", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  start;
    bit  did_rst;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a8 = 8'hAA; b8 = 8'h11; a16 = 16'h1234; b16 = 16'h4321; bin = 1'b1;
    hand_vld = 1'b1; hand_d = 8'h00; hand_b = 1'b0; hand_o = 1'b0;

    // T1: reset held 3 cycles with in_valid high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid8", {31'h0, ov8}, 32'h0);
    chk("rst_diff8", {24'h0, diff8}, 32'h0);
    chk("rst_bout8", {31'h0, bout8}, 32'h0);
    chk("rst_out_valid16", {31'h0, ov16}, 32'h0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst_in_ready8", {31'h0, in_ready8}, 32'h1);
    @(posedge clk); #1;
    chk("idle_out_valid8", {31'h0, ov8}, 32'h0);

    // T2: basic op and 2-cycle latency
    issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    chk("latency_cycle1", {31'h0, ov8}, 32'h0);
    @(posedge clk); #1;
    chk("latency_cycle2", {31'h0, ov8}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // T3/T4: borrow across the half boundary, wrap, signed overflow (back to back)
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t34_drained", q8.size(), 32'h0);

    // T5: backpressure
    out_ready = 1'b0;
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    issue(8'hC0, 8'h40, 1'b0, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'h0, in_ready8}, 32'h0);
      chk("bp_out_valid", {31'h0, ov8}, 32'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0);
    issue(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drained8", q8.size(), 32'h0);
    chk("bp_drained16", q16.size(), 32'h0);

    // T6: random stream with random backpressure and one mid-stream reset
    hand_vld = 1'b0;
    cyc      = 0;
    did_rst  = 1'b0;
    start    = acc_cnt;
    while (acc_cnt < start + 10000 && cyc < 80000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      bin = 1'($urandom_range(0, 1));
      if (!did_rst && acc_cnt >= start + 5000) begin
        did_rst = 1'b1;
        rst_n   = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        chk("midrst_out_valid8", {31'h0, ov8}, 32'h0);
        chk("midrst_out_valid16", {31'h0, ov16}, 32'h0);
        chk("midrst_in_ready8", {31'h0, in_ready8}, 32'h1);
      end
    end
    rst_n = 1'b1;
    if (cyc >= 80000) begin
      checks++;
      errors++;
      $display("FAIL random_budget actual=%0d required=%0d", acc_cnt - start, 10000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rand_drained8", q8.size(), 32'h0);
    chk("rand_drained16", q16.size(), 32'h0);
    chk("rand_idle8", {31'h0, ov8}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
